// File: rtl/enc4_2_pend.sv
// Sequential 4-to-2 encoder: captures request strobes into a pending vector and
// emits one code at a time over V/R. Define ENC4_2_RR_EN for round-robin priority.
module enc4_2_pend (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       E,
    input  logic       I0,
    input  logic       I1,
    input  logic       I2,
    input  logic       I3,
    input  logic       R,
    output logic       V,
    output logic       S1,
    output logic       S0,
    output logic       DRP,
    output logic [3:0] PND
);

    logic [3:0] pend;
    logic [3:0] req;
    logic [3:0] clr;
    logic [3:0] pend_next;
    logic [1:0] sel;
    logic       slot_free;
    logic       load;
    logic       drp_next;

    assign req       = E ? {I3, I2, I1, I0} : 4'b0000;
    assign slot_free = !V || R;
    assign load      = slot_free && (pend != 4'b0000);

`ifdef ENC4_2_RR_EN
    logic [1:0] ptr;

    // Search starts one past the last loaded index and wraps back to it.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        // NOTE: every variable gets a default first so no latch is inferred.
        sel   = ptr;
        found = 1'b0;
        idx   = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && pend[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 2'd3;
        end else if (load) begin
            ptr <= sel;
        end
    end
`else
    always_comb begin
        casez (pend)
            4'b1???: sel = 2'd3;
            4'b01??: sel = 2'd2;
            4'b001?: sel = 2'd1;
            default: sel = 2'd0;
        endcase
    end
`endif

    // Set wins over clear: a fresh request for the bit being loaded survives.
    assign clr       = load ? 4'(4'b0001 << sel) : 4'b0000;
    assign pend_next = (pend & ~clr) | req;
    assign drp_next  = |(req & pend & ~clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= 4'b0000;
            V    <= 1'b0;
            S1   <= 1'b0;
            S0   <= 1'b0;
            DRP  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register updates from pre-edge values.
            pend <= pend_next;
            DRP  <= drp_next;
            if (slot_free) begin
                V <= load;
            end
            if (load) begin
                {S1, S0} <= sel;
            end
        end
    end

    assign PND = pend;

endmodule

// File: tb/tb_enc4_2_pend.sv
// Directed scoreboard bench for enc4_2_pend; expected codes are queued when
// requests are driven and popped whenever a code is accepted (V && R).
module tb_enc4_2_pend;

    logic       clk;
    logic       rst_n;
    logic       E;
    logic       I0, I1, I2, I3;
    logic       R;
    logic       V, S1, S0, DRP;
    logic [3:0] PND;

    int         errors = 0;
    int         checks = 0;
    logic [1:0] exp_q[$];

    enc4_2_pend dut (
        .clk  (clk),
        .rst_n(rst_n),
        .E    (E),
        .I0   (I0),
        .I1   (I1),
        .I2   (I2),
        .I3   (I3),
        .R    (R),
        .V    (V),
        .S1   (S1),
        .S0   (S0),
        .DRP  (DRP),
        .PND  (PND)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic e, input logic [3:0] i, input logic r);
        E = e;
        {I3, I2, I1, I0} = i;
        R = r;
    endtask

    // Scoreboard pop happens just after inputs settle, ahead of the accepting edge.
    task automatic tick();
        logic [7:0] e;
        #1;
        if (V && R) begin
            if (exp_q.size() > 0) e = {6'b0, exp_q.pop_front()};
            else e = 8'hEE;
            check("code", {6'b0, S1, S0}, e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        logic done;
        done = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (exp_q.size() == 0 && !V) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        check({tag, "_drained"}, {7'b0, done}, 8'h01);
        check({tag, "_pnd_empty"}, {4'b0, PND}, 8'h00);
    endtask

    // Asserts reset mid-cycle and checks outputs clear before any clock edge.
    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check({tag, "_v"},   {7'b0, V},   8'h00);
        check({tag, "_s"},   {6'b0, S1, S0}, 8'h00);
        check({tag, "_drp"}, {7'b0, DRP}, 8'h00);
        check({tag, "_pnd"}, {4'b0, PND}, 8'h00);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        set_in(1'b0, 4'b0000, 1'b0);
        do_reset("rst_init");

        // Single request, code 2
        set_in(1'b1, 4'b0100, 1'b1);
        exp_q.push_back(2'd2);
        tick();
        set_in(1'b1, 4'b0000, 1'b1);
        check("single_v_pre", {7'b0, V}, 8'h00);
        tick();
        check("single_v", {7'b0, V}, 8'h01);
        check("single_s", {6'b0, S1, S0}, 8'h02);
        check("single_pnd", {4'b0, PND}, 8'h00);
        tick();
        check("single_v_after", {7'b0, V}, 8'h00);
        check("single_pnd_after", {4'b0, PND}, 8'h00);

        // Enable gating
        set_in(1'b0, 4'b1111, 1'b1);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("gate_pnd", {4'b0, PND}, 8'h00);
            check("gate_v", {7'b0, V}, 8'h00);
            check("gate_drp", {7'b0, DRP}, 8'h00);
        end

        // Stall and merge on code 1
        set_in(1'b1, 4'b0010, 1'b0);
        tick();
        set_in(1'b1, 4'b0000, 1'b0);
        tick();
        check("stall_v", {7'b0, V}, 8'h01);
        check("stall_s", {6'b0, S1, S0}, 8'h01);
        check("stall_pnd", {4'b0, PND}, 8'h00);
        check("stall_drp", {7'b0, DRP}, 8'h00);
        set_in(1'b1, 4'b0010, 1'b0);
        tick();
        check("merge1_drp", {7'b0, DRP}, 8'h00);
        check("merge1_pnd", {4'b0, PND}, 8'h02);
        tick();
        check("merge2_drp", {7'b0, DRP}, 8'h01);
        check("merge2_pnd", {4'b0, PND}, 8'h02);
        set_in(1'b1, 4'b0000, 1'b0);
        tick();
        check("merge_drp_pulse", {7'b0, DRP}, 8'h00);
        check("merge_hold_v", {7'b0, V}, 8'h01);
        check("merge_hold_s", {6'b0, S1, S0}, 8'h01);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd1);
        set_in(1'b1, 4'b0000, 1'b1);
        drain("merge");

        // Saturation with R held low
        do_reset("rst_sat");
        set_in(1'b1, 4'b1111, 1'b0);
        tick();
        tick();
        tick();
        check("sat_pnd", {4'b0, PND}, 8'h0F);
        check("sat_drp", {7'b0, DRP}, 8'h01);
        check("sat_v", {7'b0, V}, 8'h01);
`ifdef ENC4_2_RR_EN
        check("sat_s", {6'b0, S1, S0}, 8'h00);
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`else
        check("sat_s", {6'b0, S1, S0}, 8'h03);
        exp_q = '{2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
`endif
        set_in(1'b1, 4'b0000, 1'b0);
        tick();
        check("sat_drp_end", {7'b0, DRP}, 8'h00);
        check("sat_pnd_hold", {4'b0, PND}, 8'h0F);
        set_in(1'b1, 4'b0000, 1'b1);
        drain("sat");

        // E=0 keeps draining, blocks capture
        set_in(1'b1, 4'b0011, 1'b0);
        tick();
        set_in(1'b0, 4'b1111, 1'b1);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd0);
        drain("edrain");

        // Mid-transfer reset with pend=0101, V=1
        set_in(1'b1, 4'b0101, 1'b0);
        tick();
        tick();
        set_in(1'b1, 4'b0000, 1'b0);
        check("pre_rst_pnd", {4'b0, PND}, 8'h05);
        check("pre_rst_v", {7'b0, V}, 8'h01);
        do_reset("rst_mid");

        // Burst of all four requests
        set_in(1'b1, 4'b1111, 1'b1);
`ifdef ENC4_2_RR_EN
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd3};
`else
        exp_q = '{2'd3, 2'd2, 2'd1, 2'd0};
`endif
        tick();
        set_in(1'b1, 4'b0000, 1'b1);
        tick();
        for (int c = 0; c < 4; c++) begin
            check("burst_v", {7'b0, V}, 8'h01);
            tick();
        end
        check("burst_v_end", {7'b0, V}, 8'h00);
        drain("burst");

        set_in(1'b1, 4'b1001, 1'b1);
`ifdef ENC4_2_RR_EN
        exp_q = '{2'd0, 2'd3};
`else
        exp_q = '{2'd3, 2'd0};
`endif
        tick();
        set_in(1'b1, 4'b0000, 1'b1);
        drain("b1001");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/enc4_2_pend.md
Name: enc4_2_pend

Overview:
- Sequential 4-to-2 encoder, the return path of the 2-to-4 enable decoder.
- Captures one-hot or multi-hot request strobes on I3..I0 into a pending register.
- Emits one 2-bit code {S1,S0} at a time under a valid/ready handshake.
- Sits where decoded strobe lines must be folded back into a select index for a downstream consumer that can stall.

Parameters:
- None. Width is fixed at 4 requests / 2-bit code.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- E  input  1  capture enable; requests are ignored when E=0
- I0  input  1  request strobe, code 0
- I1  input  1  request strobe, code 1
- I2  input  1  request strobe, code 2
- I3  input  1  request strobe, code 3
- R  input  1  ready from consumer
- V  output  1  output code valid
- S1  output  1  code bit 1
- S0  output  1  code bit 0
- DRP  output  1  one-cycle pulse: a request merged into an already-pending bit
- PND  output  4  current pending vector {p3,p2,p1,p0}, for debug/status

Behaviour:
Reset and clocking
- One clock; reset is asynchronous and active-low: rst_n=0 immediately forces pend=0, V=0, S1=0, S0=0, DRP=0 (and the RR pointer=3 when enabled).
- Reset mid-transfer discards the pending vector and any valid code. There is no replay.
- Deassertion is sampled on clk. The first capture occurs at the first rising edge with rst_n=1.

Capture
- req = E ? {I3,I2,I1,I0} : 4'b0, sampled every rising edge.
- pend_next = (pend & ~clr) | req, where clr is the one-hot bit loaded into the output stage this edge.
- Set wins over clear: a request for bit k on the same edge that bit k is loaded keeps pend[k]=1, which yields a second code later.
- DRP_next = |(req & pend & ~clr). DRP is registered and high for exactly one cycle per offending edge.

Output stage
- The slot is free when V=0 or (V=1 and R=1).
- If the slot is free and pend != 0:
  - Select index k by priority.
  - Load {S1,S0}=k and set V=1.
  - Set clr = 1<<k.
- If the slot is free and pend = 0: V goes to 0, and S1,S0 hold their last value (don't-care when V=0).
- If V=1 and R=0: V, S1 and S0 hold stable. No pend bit is cleared. Captures continue.
- Selection uses the registered pend, not req. Latency from a request strobe at edge n to V=1 is edge n+1 if the slot is free. Back-to-back codes are possible every cycle while R=1.
- Default priority is fixed: I3 highest, then I2, I1, I0.

Boundary conditions
- All four requests in one cycle: codes 3,2,1,0 are emitted on four consecutive accepted cycles.
- R held low: pend saturates at 4'b1111. Further requests only pulse DRP; nothing is lost silently.
- E=0 while pend is non-zero: draining continues; only capture is blocked.
- R=1 with V=0 has no effect.

Optional Feature:
- Macro ENC4_2_RR_EN.
- Defined: round-robin priority.
  - A 2-bit pointer ptr holds the last loaded index (reset value 3, so index 0 is highest after reset).
  - Search order is ptr+1, ptr+2, ptr+3, ptr (mod 4).
  - ptr updates to k on each load.
- Undefined: fixed priority, I3 highest. No pointer register exists.

Test Plan:
- Reset check: rst_n=0 asserted mid-cycle with pend=4'b0101 and V=1 -> V, S1, S0, DRP and PND all read 0 immediately, before the next clock edge.
- Single request: E=1, I2 pulsed for 1 cycle, R=1 -> next cycle V=1, {S1,S0}=2'b10. The cycle after, V=0 and PND=0.
- Enable gating: E=0 with I0..I3=1111 for 3 cycles -> PND stays 0, V stays 0, DRP stays 0.
- Stall and merge: R=0, I1 pulsed on two separate cycles -> V=1 with code 01 held stable, PND=0000 after the load, DRP=0. Then I1 while code 01 is still pending in PND (pulse again after a further I1) -> DRP=1 for one cycle. Release R=1 -> code 01 is accepted, and exactly one further code 01 follows.
- Burst, fixed priority: E=1, I=1111 in one cycle, R=1 -> codes 3,2,1,0 on consecutive cycles, then V=0.
- Burst, with ENC4_2_RR_EN defined: I=1111 after reset -> codes 0,1,2,3. Then I=1001 -> code 0, then 3.
